rtc_bus_ctrl: RTL and testbench

Bus-cycle generator for the external real-time clock's multiplexed 8-bit address/data bus.
- Accepts single read or write transactions from the RTC state machines over a req/busy/done handshake.
- Produces the address phase and data phase on DATA_ADDRESS with ChipSelect/Read/Write/AoD strobe timing.
- Sits directly downstream of the state-machine cluster and drives the top-level RTC pins.

---
 rtl/rtc_bus_ctrl_if.sv | 22 ++
 rtl/rtc_bus_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_ctrl_if.sv
// Handshake between the RTC state-machine cluster and the bus-cycle generator.
// The master issues single read/write transactions. The slave (rtc_bus_ctrl)
// reports progress and returns read data.
interface rtc_bus_ctrl_if;
  logic       req;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output req, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  req, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for the external RTC's multiplexed 8-bit address/data bus.
// Each transaction has two phases:
//   - an address phase, always strobed with Write;
//   - a data phase, strobed with Write or Read depending on rw.
// The two phases are separated by a tristated gap. Every pin and every
// handshake output comes straight from a register.
module rtc_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 10,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_ctrl_if.slave      bus,
  inout  wire  [7:0]         DATA_ADDRESS,
  output logic               ChipSelect,
  output logic               Read,
  output logic               Write,
  output logic               AoD
);

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_PULSE,
    A_HOLD,
    GAP,
    D_SETUP,
    D_PULSE,
    D_HOLD
  } state_t;

  // Phase counters count down to zero, so each one loads (length - 1).
  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       rw_q;
  logic [7:0] wdata_q;
  logic [7:0] bus_out;
  logic       drive_en;

  // The pad driver is enabled only by a register, so it never glitches.
  assign DATA_ADDRESS = drive_en ? bus_out : 'z;

  // Transaction sequencer. Outputs are set on the edge that enters a state,
  // which keeps every pin registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      bus_out    <= '0;
      drive_en   <= 1'b0;
      ChipSelect <= 1'b1;
      Read       <= 1'b1;
      Write      <= 1'b1;
      AoD        <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            rw_q     <= bus.rw;
            wdata_q  <= bus.wdata;
            bus_out  <= bus.addr;
            drive_en <= 1'b1;
            AoD      <= 1'b0;
            bus.busy <= 1'b1;
            cnt      <= LD_SETUP;
            state    <= A_SETUP;
          end
        end

        A_SETUP: begin
          if (cnt == '0) begin
            ChipSelect <= 1'b0;
            Write      <= 1'b0;
            cnt        <= LD_PULSE;
            state      <= A_PULSE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        A_PULSE: begin
          if (cnt == '0) begin
            ChipSelect <= 1'b1;
            Write      <= 1'b1;
            cnt        <= LD_HOLD;
            state      <= A_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        A_HOLD: begin
          if (cnt == '0) begin
            AoD      <= 1'b1;
            drive_en <= 1'b0;
            cnt      <= LD_GAP;
            state    <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        GAP: begin
          if (cnt == '0) begin
            // Reads leave the bus released for the RTC for the whole data phase.
            bus_out  <= wdata_q;
            drive_en <= ~rw_q;
            cnt      <= LD_SETUP;
            state    <= D_SETUP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        D_SETUP: begin
          if (cnt == '0) begin
            ChipSelect <= 1'b0;
            if (rw_q) begin
              Read <= 1'b0;
            end else begin
              Write <= 1'b0;
            end
            cnt   <= LD_PULSE;
            state <= D_PULSE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        D_PULSE: begin
          if (cnt == '0) begin
            // Sample while Read is still low, on the edge that ends the pulse.
            if (rw_q) begin
              bus.rdata <= DATA_ADDRESS;
            end
            ChipSelect <= 1'b1;
            Read       <= 1'b1;
            Write      <= 1'b1;
            cnt        <= LD_HOLD;
            state      <= D_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        D_HOLD: begin
          if (cnt == '0) begin
            drive_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pin-level invariants of the RTC bus protocol.
  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!reset)
    !(!Read && !Write));

  a_cs_in_pulse: assert property (@(posedge clk) disable iff (!reset)
    !ChipSelect |-> (state == A_PULSE || state == D_PULSE));

  a_no_drive_on_read: assert property (@(posedge clk) disable iff (!reset)
    !(drive_en && !Read));

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl.
// Expected pin values come from each cycle's position within the transaction.
// A scoreboard pairs every completion with the read data it should return.
module tb_rtc_bus_ctrl;
  localparam int TS = 2, TP = 10, TH = 2, TG = 4;
  localparam int A_PL   = TS;
  localparam int A_PH   = TS + TP;
  localparam int A_END  = TS + TP + TH;
  localparam int D_BEG  = A_END + TG;
  localparam int D_PL   = D_BEG + TS;
  localparam int D_PH   = D_BEG + TS + TP;
  localparam int BUSY_N = D_BEG + TS + TP + TH;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs;
    logic       rd_n;
    logic       wr_n;
    logic       aod;
    logic [7:0] bus;
  } pins_t;

  typedef struct {
    logic       rw;
    logic [7:0] a;
    logic [7:0] w;
    logic [7:0] rd;
    int         spur_k;
    logic       chain;
    logic [7:0] ca;
    logic [7:0] cw;
  } vec_t;

  typedef struct {
    logic       rw;
    logic [7:0] rdata;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  wire  [7:0] DATA_ADDRESS;
  logic       ChipSelect, Read, Write, AoD;
  logic       exp_drive = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] model_rdata = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  int         done_expected = 0;
  sb_t        sb[$];
  vec_t       tbl[6];

  rtc_bus_ctrl_if bus_if ();

  rtc_bus_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .DATA_ADDRESS (DATA_ADDRESS),
    .ChipSelect   (ChipSelect),
    .Read         (Read),
    .Write        (Write),
    .AoD          (AoD)
  );

  // Stand-in for the RTC: it drives read data while Read is low, and holds the
  // bus at 0x00 whenever the controller should be released.
  assign DATA_ADDRESS = exp_drive ? 8'hzz : ((Read == 1'b0) ? rd_val : 8'h00);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected pins for cycle k after the accepting edge (k = BUSY_N is the done cycle).
  function automatic pins_t expect_pins(input int k, input logic rw,
                                        input logic [7:0] a, input logic [7:0] w,
                                        input logic [7:0] rd);
    pins_t p;
    p = '{busy: 1'b1, done: 1'b0, cs: 1'b1, rd_n: 1'b1, wr_n: 1'b1, aod: 1'b1, bus: 8'h00};
    if (k >= BUSY_N) begin
      p.busy = 1'b0;
      p.done = (k == BUSY_N);
    end else if (k < A_END) begin
      p.aod = 1'b0;
      p.bus = a;
      if (k >= A_PL && k < A_PH) begin
        p.cs   = 1'b0;
        p.wr_n = 1'b0;
      end
    end else if (k >= D_BEG) begin
      if (!rw) p.bus = w;
      if (k >= D_PL && k < D_PH) begin
        p.cs = 1'b0;
        if (rw) begin
          p.rd_n = 1'b0;
          p.bus  = rd;
        end else begin
          p.wr_n = 1'b0;
        end
      end
    end
    return p;
  endfunction

  function automatic pins_t actual_pins();
    return '{busy: bus_if.busy, done: bus_if.done, cs: ChipSelect, rd_n: Read,
             wr_n: Write, aod: AoD, bus: DATA_ADDRESS};
  endfunction

  task automatic check_idle(input string nm);
    pins_t e;
    e = expect_pins(BUSY_N + 1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk({nm, "_pins"}, 32'(actual_pins()), 32'(e));
    chk({nm, "_rdata"}, 32'(bus_if.rdata), 32'(model_rdata));
  endtask

  // Run one transaction: request, then check cycles 0..last_k after acceptance.
  task automatic run_txn(input vec_t v, input int last_k);
    pins_t e;
    bus_if.req   = 1'b1;
    bus_if.rw    = v.rw;
    bus_if.addr  = v.a;
    bus_if.wdata = v.w;
    if (last_k == BUSY_N) begin
      sb.push_back('{rw: v.rw, rdata: (v.rw ? v.rd : model_rdata)});
      done_expected++;
    end
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clk);
      #1;
      exp_drive = (k < A_END) || (k >= D_BEG && k < BUSY_N && !v.rw);
      rd_val    = v.rd;
      #1;
      if (v.rw && k == D_PH) model_rdata = v.rd;
      e = expect_pins(k, v.rw, v.a, v.w, v.rd);
      chk($sformatf("pins_a%0h_k%0d", v.a, k), 32'(actual_pins()), 32'(e));
      chk($sformatf("rdata_a%0h_k%0d", v.a, k), 32'(bus_if.rdata), 32'(model_rdata));
      if (k == BUSY_N && bus_if.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'(1), 32'(0));
        end else begin
          sb_t s;
          s = sb.pop_front();
          chk($sformatf("sb_rdata_a%0h", v.a), 32'(bus_if.rdata), 32'(s.rdata));
        end
      end
      if (k == 0) bus_if.req = 1'b0;
      if (k == v.spur_k) begin
        bus_if.req   = 1'b1;
        bus_if.rw    = 1'b1;
        bus_if.addr  = 8'h99;
        bus_if.wdata = 8'h99;
      end
      if (k == v.spur_k + 1) bus_if.req = 1'b0;
      if (v.chain && k == BUSY_N - 1) begin
        bus_if.req   = 1'b1;
        bus_if.rw    = 1'b0;
        bus_if.addr  = v.ca;
        bus_if.wdata = v.cw;
      end
    end
  endtask

  initial begin
    vec_t ab;
    tbl[0] = '{1'b0, 8'h21, 8'h45, 8'h00, -1, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 8'h00, 8'h37, -1, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 8'h30, 8'h5C, 8'h00,  5, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{1'b0, 8'h44, 8'hA1, 8'h00, 22, 1'b1, 8'h10, 8'h6B};
    tbl[4] = '{1'b0, 8'h10, 8'h6B, 8'h00, -1, 1'b0, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 8'hFE, 8'h00, 8'hC3, 21, 1'b0, 8'h00, 8'h00};

    bus_if.req   = 1'b0;
    bus_if.rw    = 1'b0;
    bus_if.addr  = 8'h00;
    bus_if.wdata = 8'h00;
    reset        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_drive = 1'b0;
    #1;
    check_idle("reset");
    reset = 1'b1;
    @(posedge clk);
    #2;
    check_idle("post_reset");

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], BUSY_N);
    end

    @(posedge clk);
    #2;
    check_idle("idle_after_table");

    // Reset during the read data pulse: abort at the next edge, rdata cleared.
    ab = '{1'b1, 8'h5A, 8'h00, 8'h77, -1, 1'b0, 8'h00, 8'h00};
    run_txn(ab, D_PL + 4);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_drive   = 1'b0;
    model_rdata = 8'h00;
    #1;
    check_idle("abort");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      check_idle("after_abort");
    end

    chk("done_pulses", 32'(done_seen), 32'(done_expected));
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
